// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  // Load context carried across the RAM read cycle
  typedef struct packed {
    logic [2:0] f3;
    logic [1:0] off;
    logic [4:0] rd;
    logic       rw;
    logic       mis;
    logic       m2r;
  } ld_pend_t;

  // Unsupported encodings (011, 11x) fall through to word access
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_ram.sv
// Single-port data RAM with per-byte write enables and a registered read.
module lsu_data_ram
  import mem_lsu_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = 12
) (
  input  logic                clk,
  input  logic                re_i,
  input  logic [XLEN/8-1:0]   be_i,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic [XLEN-1:0]     rdata_o
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0][7:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0]    rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (be_i[b]) mem[idx_i][b] <= wdata_i[8*b +: 8];
    if (re_i) rdata_q <= mem[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: byte/half/word loads and stores with valid/ready on both sides.
// Optional MEM_MISALIGN_TRAP_EN: flag misaligned H/W instead of force-aligning.
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            misalign
);

  localparam int NB = XLEN / 8;

  lsu_state_e      state_q, state_d;
  ld_pend_t        pend_q, pend_d;
  logic [XLEN-1:0] palu_q, palu_d;
  logic            ov_q, ov_d, rw_q, rw_d, mis_q, mis_d;
  logic [XLEN-1:0] wb_q, wb_d;
  logic [4:0]      rd_q, rd_d;

  lsu_size_e       sz;
  logic [1:0]      off_al;
  logic            misal, accept;
  logic [NB-1:0]   be, we;
  logic [XLEN-1:0] wd, rdata, fmt;
  logic [7:0]      lb;
  logic [15:0]     lh;

  assign in_ready = (state_q == IDLE) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign sz       = f3_size(funct3);

  always_comb begin
    case (sz)
      SZ_B:    off_al = alu_result[1:0];
      SZ_H:    off_al = {alu_result[1], 1'b0};
      default: off_al = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = (mem_read || mem_write) &&
                 ((sz == SZ_H && alu_result[0]) || (sz == SZ_W && alu_result[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    be = '1;
    wd = store_data;
    case (sz)
      SZ_B: begin be = NB'(1) << off_al; wd = {NB{store_data[7:0]}}; end
      SZ_H: begin be = NB'(3) << off_al; wd = {(NB/2){store_data[15:0]}}; end
      default: ;
    endcase
  end

  assign we = (accept && mem_write && !misal) ? be : '0;

  lsu_data_ram #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk     (clk),
    .re_i    (accept && mem_read),
    .be_i    (we),
    .idx_i   (alu_result[IDX_W+1:2]),
    .wdata_i (wd),
    .rdata_o (rdata)
  );

  // Lane select and extension of the word returned one cycle after issue
  always_comb begin
    lb  = rdata[8*pend_q.off +: 8];
    lh  = rdata[16*pend_q.off[1] +: 16];
    fmt = rdata;
    case (f3_size(pend_q.f3))
      SZ_B: fmt = pend_q.f3[2] ? {{(XLEN-8){1'b0}}, lb}  : {{(XLEN-8){lb[7]}}, lb};
      SZ_H: fmt = pend_q.f3[2] ? {{(XLEN-16){1'b0}}, lh} : {{(XLEN-16){lh[15]}}, lh};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    palu_d  = palu_q;
    ov_d    = ov_q && !out_ready;
    wb_d    = wb_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    mis_d   = mis_q;
    if (state_q == LOAD_WAIT) begin
      state_d = IDLE;
      ov_d    = 1'b1;
      wb_d    = pend_q.mis ? '0 : (pend_q.m2r ? fmt : palu_q);
      rd_d    = pend_q.rd;
      rw_d    = pend_q.rw && !pend_q.mis;
      mis_d   = pend_q.mis;
    end else if (accept) begin
      if (mem_read) begin
        state_d = LOAD_WAIT;
        pend_d  = '{f3: funct3, off: off_al, rd: rd_in, rw: reg_write_in,
                    mis: misal, m2r: mem_to_reg};
        palu_d  = alu_result;
      end else begin
        ov_d  = 1'b1;
        wb_d  = alu_result;
        rd_d  = rd_in;
        rw_d  = reg_write_in && !misal;
        mis_d = misal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      palu_q  <= '0;
      ov_q    <= 1'b0;
      wb_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      palu_q  <= palu_d;
      ov_q    <= ov_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mis_q   <= mis_d;
    end
  end

  assign out_valid     = ov_q;
  assign wb_data       = wb_q;
  assign rd_out        = rd_q;
  assign reg_write_out = rw_q;
  assign misalign      = mis_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed ops push expectations, a monitor checks WB transfers.
module tb_mem_stage_lsu;
  import mem_lsu_pkg::*;

  localparam int DW = 4096;

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 0, in_ready, mem_read = 0, mem_write = 0, mem_to_reg = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] alu_result = 0, store_data = 0, wb_data;
  logic [4:0]  rd_in = 0, rd_out;
  logic        reg_write_in = 0, out_valid, out_ready = 1, reg_write_out, misalign;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(DW), .IDX_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .funct3(funct3), .alu_result(alu_result), .store_data(store_data),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .out_valid(out_valid),
    .out_ready(out_ready), .wb_data(wb_data), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got wb 0x%08h with empty scoreboard", wb_data);
      end else begin
        e = sb.pop_front();
        chk("wb_data", wb_data, e.wb);
        chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        chk("reg_write_out", {31'd0, reg_write_out}, {31'd0, e.rw});
        chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
      end
    end
  end

  // Present one op from posedge+1, wait for acceptance, optionally push its expected WB payload.
  task automatic op(input logic ld, input logic st, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rdi,
                    input logic rwi, input logic push, input logic [31:0] ewb,
                    input logic erw, input logic emis);
    int n = 0;
    mem_read = ld; mem_write = st; mem_to_reg = ld; funct3 = f3;
    alu_result = a; store_data = sd; rd_in = rdi; reg_write_in = rwi; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stuck 0 for addr 0x%08h", a);
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{ewb, rdi, erw, emis});
    @(posedge clk); #1;
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_rd_out", {27'd0, rd_out}, 0);
    chk("rst_reg_write", {31'd0, reg_write_out}, 0);
    chk("rst_misalign", {31'd0, misalign}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset while a load is waiting on the RAM
    op(1, 0, F3_W, 32'h0, 0, 5'd5, 1, 0, 0, 0, 0);
    chk("loadwait_in_ready", {31'd0, in_ready}, 0);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst_out_valid", {31'd0, out_valid}, 0);
    chk("postrst_in_ready", {31'd0, in_ready}, 1);

    // Sign/zero extension of byte and half loads
    op(0, 1, F3_W,  32'h10, 32'h8000_00F1, 5'd1, 0, 1, 32'h10, 0, 0);
    op(1, 0, F3_B,  32'h10, 0, 5'd2, 1, 1, 32'hFFFF_FFF1, 1, 0);
    op(1, 0, F3_BU, 32'h13, 0, 5'd3, 1, 1, 32'h0000_0080, 1, 0);
    op(1, 0, F3_HU, 32'h12, 0, 5'd4, 1, 1, 32'h0000_8000, 1, 0);
    op(1, 0, F3_H,  32'h12, 0, 5'd5, 1, 1, 32'hFFFF_8000, 1, 0);
    op(1, 0, F3_W,  32'h10, 0, 5'd6, 1, 1, 32'h8000_00F1, 1, 0);

    // Byte-lane stores with back-to-back load, plus 2-cycle latency check
    op(0, 1, F3_W, 32'h20, 32'h1122_3344, 5'd7, 0, 1, 32'h20, 0, 0);
    op(0, 1, F3_B, 32'h21, 32'hFFFF_FFAB, 5'd8, 0, 1, 32'h21, 0, 0);
    op(1, 0, F3_W, 32'h20, 0, 5'd9, 1, 1, 32'h1122_AB44, 1, 0);
    chk("ld_lat1_valid", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    chk("ld_lat2_valid", {31'd0, out_valid}, 1);
    chk("ld_lat2_data", wb_data, 32'h1122_AB44);
    op(0, 1, F3_H, 32'h22, 32'h5555_CAFE, 5'd10, 0, 1, 32'h22, 0, 0);
    op(1, 0, F3_W, 32'h20, 0, 5'd11, 1, 1, 32'hCAFE_AB44, 1, 0);

    // Back-pressure on a pass-through op
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    op(0, 0, F3_W, 32'h1234, 0, 5'd12, 1, 1, 32'h1234, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 1);
      chk("bp_wb_hold", wb_data, 32'h1234);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_cleared", {31'd0, out_valid}, 0);

    // Address wraps modulo the RAM size
    op(0, 1, F3_W, DW*4 + 4, 32'hDEAD_BEEF, 5'd13, 0, 1, DW*4 + 4, 0, 0);
    op(1, 0, F3_W, 32'h4, 0, 5'd14, 1, 1, 32'hDEAD_BEEF, 1, 0);

    // Misaligned half/word accesses
    op(0, 1, F3_W, 32'h30, 32'h0102_0304, 5'd15, 0, 1, 32'h30, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    op(1, 0, F3_W, 32'h22, 0, 5'd16, 1, 1, 32'h0, 0, 1);
    op(0, 1, F3_W, 32'h31, 32'h9999_9999, 5'd17, 1, 1, 32'h31, 0, 1);
    op(1, 0, F3_W, 32'h30, 0, 5'd18, 1, 1, 32'h0102_0304, 1, 0);
    op(1, 0, F3_H, 32'h31, 0, 5'd19, 1, 1, 32'h0, 0, 1);
`else
    op(1, 0, F3_W, 32'h22, 0, 5'd16, 1, 1, 32'hCAFE_AB44, 1, 0);
    op(0, 1, F3_W, 32'h31, 32'h9999_9999, 5'd17, 1, 1, 32'h31, 1, 0);
    op(1, 0, F3_W, 32'h30, 0, 5'd18, 1, 1, 32'h9999_9999, 1, 0);
    op(1, 0, F3_H, 32'h31, 0, 5'd19, 1, 1, 32'hFFFF_9999, 1, 0);
`endif

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
